// File: rtl/br_redirect_ctrl_pkg.sv
// Shared types for branch-mispredict recovery: CDB branch result layout, redirect FSM states
// and the ROB age helper used to keep only the oldest pending mispredict.
package br_redirect_ctrl_pkg;

  localparam int PKG_ROB_DEPTH = 16;
  localparam int CDB_TAG_W     = $clog2(PKG_ROB_DEPTH);

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    IS_BR   = 2'd1,
    IS_JAL  = 2'd2,
    IS_JALR = 2'd3
  } bj_t;

  typedef struct packed {
    logic                 valid;
    bj_t                  bj;
    logic                 take_target;
    logic [31:0]          target_pc;
    logic [CDB_TAG_W-1:0] rob_tag;
  } cdb_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FLUSH = 2'd1,
    RD_DRAIN = 2'd2
  } redirect_state_t;

  // Distance from the ROB head; the wrap subtraction makes the oldest entry age 0.
  function automatic logic [CDB_TAG_W-1:0] rob_age(input logic [CDB_TAG_W-1:0] tag,
                                                   input logic [CDB_TAG_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/br_redirect_ctrl.sv
// Holds the oldest unresolved mispredict and, when the ROB commits it, pulses flush/redirect
// and stalls fetch while the front end drains. Optional counters: define BR_REDIRECT_STATS_EN.
//
// state    | meaning
// RD_IDLE  | watching the CDB for mispredicts, waiting for the pending tag to commit
// RD_FLUSH | one-cycle squash plus fetch redirect to the corrected PC
// RD_DRAIN | fetch held off for DRAIN_CYCLES cycles while the front end empties
module br_redirect_ctrl
  import br_redirect_ctrl_pkg::*;
#(
  parameter int  ROB_DEPTH    = 16,
  parameter int  DRAIN_CYCLES = 2,
  localparam int TAG_W        = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  cdb_t             cdb_br_in,
  input  logic [TAG_W-1:0] rob_head,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             fetch_stall,
`ifdef BR_REDIRECT_STATS_EN
  output logic [31:0]      br_resolved_cnt,
  output logic [31:0]      br_mispred_cnt,
`endif
  output logic             busy
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  redirect_state_t  state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic             flush_q, flush_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             fetch_stall_q, fetch_stall_d;
  logic             busy_q, busy_d;

  logic             br_seen;
  logic             mispredict;
  logic             commit_hit;
  logic             is_older;

  assign br_seen    = cdb_br_in.valid && (cdb_br_in.bj != NONE);
  assign mispredict = br_seen && cdb_br_in.take_target;
  assign commit_hit = commit_valid && pend_valid_q && (commit_tag == pend_tag_q);
  assign is_older   = rob_age(cdb_br_in.rob_tag, rob_head) < rob_age(pend_tag_q, rob_head);

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_tag_d   = pend_tag_q;
    pend_pc_d    = pend_pc_q;
    drain_cnt_d  = drain_cnt_q;

    case (state_q)
      RD_IDLE: begin
        // A capture in the commit cycle is younger than the flushed branch, so it is dropped.
        if (commit_hit) begin
          state_d = RD_FLUSH;
        end else if (mispredict && (!pend_valid_q || is_older)) begin
          pend_valid_d = 1'b1;
          pend_tag_d   = cdb_br_in.rob_tag;
          pend_pc_d    = cdb_br_in.target_pc;
        end
      end
      RD_FLUSH: begin
        pend_valid_d = 1'b0;
        drain_cnt_d  = DRAIN_LOAD;
        state_d      = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = RD_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase

    flush_d          = (state_d == RD_FLUSH);
    redirect_valid_d = (state_d == RD_FLUSH);
    redirect_pc_d    = (state_d == RD_FLUSH) ? pend_pc_q : 32'h0;
    fetch_stall_d    = (state_d != RD_IDLE);
    busy_d           = pend_valid_d || (state_d != RD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RD_IDLE;
      pend_valid_q     <= 1'b0;
      pend_tag_q       <= '0;
      pend_pc_q        <= 32'h0;
      drain_cnt_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      fetch_stall_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_valid_q     <= pend_valid_d;
      pend_tag_q       <= pend_tag_d;
      pend_pc_q        <= pend_pc_d;
      drain_cnt_q      <= drain_cnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      fetch_stall_q    <= fetch_stall_d;
      busy_q           <= busy_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign fetch_stall    = fetch_stall_q;
  assign busy           = busy_q;

`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] resolved_cnt_q, resolved_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    resolved_cnt_d = resolved_cnt_q;
    mispred_cnt_d  = mispred_cnt_q;
    if ((state_q == RD_IDLE) && br_seen) begin
      resolved_cnt_d = resolved_cnt_q + 32'd1;
    end
    if ((state_q == RD_IDLE) && (state_d == RD_FLUSH)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resolved_cnt_q <= 32'h0;
      mispred_cnt_q  <= 32'h0;
    end else begin
      resolved_cnt_q <= resolved_cnt_d;
      mispred_cnt_q  <= mispred_cnt_d;
    end
  end

  assign br_resolved_cnt = resolved_cnt_q;
  assign br_mispred_cnt  = mispred_cnt_q;
`endif

endmodule
